// File: rtl/alu_pkg.sv
// ALU opcode, flag-index and shared-unit state definitions.
// No logic; types and constants only.
// Not applicable: carries no handshakes.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLL  = 4'd6,
    SLTU = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  // Bit positions inside the {O,N,Z,C} flag nibble.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 3;

  // Occupancy of the single shared result register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  // Codes above the last defined opcode make the ALU return zero.
  function automatic logic is_illegal_op(input logic [3:0] ctrl);
    return ctrl > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundles requester channels, the ALU operand/result wires and the response channel.
// No latency: wires only.
// Requests and response use valid/ready; the ALU leg is purely combinational.
interface alu_share_arb_if #(
  parameter int REG_BITS = 32,
  parameter int NUM_REQ  = 2,
  parameter int ID_BITS  = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0][REG_BITS-1:0] req_a;
  logic [NUM_REQ-1:0][REG_BITS-1:0] req_b;
  logic [NUM_REQ-1:0][3:0]          req_ctrl;

  logic [REG_BITS-1:0]              alu_a;
  logic [REG_BITS-1:0]              alu_b;
  logic [3:0]                       alu_ctrl;
  logic [REG_BITS-1:0]              alu_c;
  logic [3:0]                       alu_onzc;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [ID_BITS-1:0]               rsp_id;
  logic [REG_BITS-1:0]              rsp_data;
  logic [3:0]                       rsp_onzc;
  logic                             rsp_illegal;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, alu_c, alu_onzc, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl,
           rsp_valid, rsp_id, rsp_data, rsp_onzc, rsp_illegal
  );

  // Requesters, ALU and response consumer side.
  modport master (
    output req_valid, req_a, req_b, req_ctrl, alu_c, alu_onzc, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl,
           rsp_valid, rsp_id, rsp_data, rsp_onzc, rsp_illegal
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted request at or above ptr, wrapping.
// Combinational, zero latency.
// No backpressure of its own; the caller decides whether the grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_BITS-1:0] ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_BITS-1:0] grant_idx_o,
  output logic               any_grant_o
);

  // Requests rotated so bit 0 is the requester at ptr_i.
  logic [NUM_REQ-1:0] rot_w;
  int                 off_w;

  assign rot_w = NUM_REQ'({req_i, req_i} >> ptr_i);

  // Lowest set bit of the rotated vector is the winner; map it back to an absolute index.
  always_comb begin
    off_w       = 0;
    any_grant_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_w[k]) begin
        off_w       = k;
        any_grant_o = 1'b1;
      end
    end
    grant_idx_o = ID_BITS'((int'(ptr_i) + off_w) % NUM_REQ);
  end

  // One-hot form of the winning index.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = any_grant_o && (grant_idx_o == ID_BITS'(i));
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin priority.
// Accepted request -> registered response one cycle later; one result per cycle sustained.
// A full, unaccepted result register blocks all req_ready; draining frees the slot in the same cycle.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int REG_BITS = 32,
  parameter int NUM_REQ  = 2,
  parameter int ID_BITS  = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_share_arb_if.slave bus
);

  arb_state_e          state_q, state_d;
  logic [ID_BITS-1:0]  rr_ptr_q, rr_ptr_d;

  logic [ID_BITS-1:0]  rsp_id_q;
  logic [REG_BITS-1:0] rsp_data_q;
  logic [3:0]          rsp_onzc_q;
  logic                rsp_illegal_q;

  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_BITS-1:0]  grant_idx;
  logic                any_grant;
  logic                can_issue;
  logic                fire;

  logic [REG_BITS-1:0] mux_a;
  logic [REG_BITS-1:0] mux_b;
  logic [3:0]          mux_ctrl;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // Steer the granted requester onto the ALU; with no grant drive zeros so the ALU never sees X.
  always_comb begin
    mux_a    = '0;
    mux_b    = '0;
    mux_ctrl = '0;
    if (any_grant) begin
      mux_a    = bus.req_a[grant_idx];
      mux_b    = bus.req_b[grant_idx];
      mux_ctrl = bus.req_ctrl[grant_idx];
    end
  end

  assign bus.alu_a    = mux_a;
  assign bus.alu_b    = mux_b;
  assign bus.alu_ctrl = mux_ctrl;

  // Issue decision, result-register occupancy and priority rotation (rotates only on fire).
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    can_issue = (state_q == ST_EMPTY) || bus.rsp_ready;
    fire      = can_issue && any_grant;
    case (state_q)
      ST_EMPTY: if (fire) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !fire) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (fire) begin
      rr_ptr_d = (grant_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign bus.req_ready = can_issue ? grant_oh : '0;

  // State and priority pointer; reset discards any held result and returns priority to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Result register loads only on fire; a plain drain leaves the old contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_onzc_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else if (fire) begin
      rsp_id_q      <= grant_idx;
      rsp_data_q    <= bus.alu_c;
      rsp_onzc_q    <= bus.alu_onzc;
      rsp_illegal_q <= is_illegal_op(mux_ctrl);
    end
  end

  assign bus.rsp_valid   = (state_q == ST_FULL);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_onzc    = rsp_onzc_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU stub and a response scoreboard.
// Expected responses are queued when a request is driven and checked when the response drains.
// Covers carry/overflow flags, fairness, backpressure stall, illegal opcodes and async reset.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int RB = 32;
  localparam int NR = 2;
  localparam int IB = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_share_arb_if #(.REG_BITS(RB), .NUM_REQ(NR), .ID_BITS(IB)) bus ();

  alu_share_arb #(.REG_BITS(RB), .NUM_REQ(NR), .ID_BITS(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU stub driving the combinational C/ONZC inputs.
  logic [32:0] ext_w;
  logic [31:0] res_w;
  logic        cf_w, of_w, legal_w;

  always_comb begin
    ext_w   = '0;
    res_w   = '0;
    cf_w    = 1'b0;
    of_w    = 1'b0;
    legal_w = !is_illegal_op(bus.alu_ctrl);
    case (bus.alu_ctrl)
      ADD: begin
        ext_w = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        res_w = ext_w[31:0];
        cf_w  = ext_w[32];
        of_w  = (bus.alu_a[31] == bus.alu_b[31]) && (res_w[31] != bus.alu_a[31]);
      end
      SUB: begin
        ext_w = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        res_w = ext_w[31:0];
        cf_w  = ext_w[32];
        of_w  = (bus.alu_a[31] != bus.alu_b[31]) && (res_w[31] != bus.alu_a[31]);
      end
      AND:  res_w = bus.alu_a & bus.alu_b;
      OR:   res_w = bus.alu_a | bus.alu_b;
      XOR:  res_w = bus.alu_a ^ bus.alu_b;
      SLT:  res_w = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      SLL:  res_w = bus.alu_a << bus.alu_b[4:0];
      SLTU: res_w = {31'b0, bus.alu_a < bus.alu_b};
      SRL:  res_w = bus.alu_a >> bus.alu_b[4:0];
      SRA:  res_w = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default: res_w = '0;
    endcase
  end

  assign bus.alu_c    = res_w;
  assign bus.alu_onzc = {of_w, legal_w & res_w[31], legal_w & (res_w == 32'd0), cf_w};

  typedef struct packed {
    logic [IB-1:0] id;
    logic [31:0]   data;
    logic [3:0]    onzc;
    logic          ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard: every response handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("rsp_id",      64'(bus.rsp_id),      64'(mon_e.id));
        chk("rsp_data",    64'(bus.rsp_data),    64'(mon_e.data));
        chk("rsp_onzc",    64'(bus.rsp_onzc),    64'(mon_e.onzc));
        chk("rsp_illegal", 64'(bus.rsp_illegal), 64'(mon_e.ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl);
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_ctrl[i]  = ctrl;
    bus.req_valid[i] = 1'b1;
  endtask

  // Single request from requester i with the response consumer always ready.
  task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctrl, input exp_t e);
    bus.req_valid = '0;
    set_req(i, a, b, ctrl);
    sb_q.push_back(e);
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'(2'b01) << i);
    chk("single_pre_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_latency", 64'(bus.rsp_valid), 64'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ctrl  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
    chk("rst_rsp_id",      64'(bus.rsp_id),      64'd0);
    chk("rst_rsp_data",    64'(bus.rsp_data),    64'd0);
    chk("rst_rsp_onzc",    64'(bus.rsp_onzc),    64'd0);
    chk("rst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    chk("rst_req_ready",   64'(bus.req_ready),   64'd0);
    chk("idle_alu_a",      64'(bus.alu_a),       64'd0);
    tick();
    rst_n = 1'b1;

    // Carry-out wraps to zero; then signed overflow into the sign bit.
    bus.rsp_ready = 1'b1;
    single(0, 32'hFFFF_FFFF, 32'd1, ADD, '{id: 1'b0, data: 32'h0, onzc: 4'b0011, ill: 1'b0});
    single(1, 32'h7FFF_FFFF, 32'd1, ADD, '{id: 1'b1, data: 32'h8000_0000, onzc: 4'b1100, ill: 1'b0});

    // Both requesters valid continuously: alternating grants, one result per cycle.
    set_req(0, 32'd5, 32'd5, SUB);
    set_req(1, 32'h8000_0000, 32'd4, SRA);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        sb_q.push_back('{id: 1'b0, data: 32'h0, onzc: 4'b0010, ill: 1'b0});
      else
        sb_q.push_back('{id: 1'b1, data: 32'hF800_0000, onzc: 4'b0100, ill: 1'b0});
      @(negedge clk);
      chk("rr_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("rr_rsp_valid", 64'(bus.rsp_valid), (k > 0) ? 64'd1 : 64'd0);
      if (k == 1) chk("rr_alu_a_req1", 64'(bus.alu_a), 64'h8000_0000);
      tick();
    end
    bus.req_valid = '0;
    @(negedge clk);
    chk("rr_last_valid", 64'(bus.rsp_valid), 64'd1);
    tick();

    // Backpressure: held result blocks all requesters, then drain and issue in the same cycle.
    bus.rsp_ready = 1'b0;
    set_req(0, 32'd1, 32'd2, ADD);
    sb_q.push_back('{id: 1'b0, data: 32'd3, onzc: 4'b0000, ill: 1'b0});
    @(negedge clk);
    chk("stall_first_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = '0;
    set_req(1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, XOR);
    sb_q.push_back('{id: 1'b1, data: 32'hFFFF_FFFF, onzc: 4'b0100, ill: 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready",    64'(bus.req_ready), 64'd0);
      chk("stall_valid",    64'(bus.rsp_valid), 64'd1);
      chk("stall_data",     64'(bus.rsp_data),  64'd3);
      chk("stall_id",       64'(bus.rsp_id),    64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 64'(bus.req_ready), 64'd2);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("stall_next_valid", 64'(bus.rsp_valid), 64'd1);
    tick();

    // Undefined control code.
    single(0, 32'd123, 32'd456, 4'hF, '{id: 1'b0, data: 32'h0, onzc: 4'b0000, ill: 1'b1});

    // Asynchronous reset while a result is held; priority returns to requester 0.
    bus.rsp_ready = 1'b0;
    set_req(1, 32'd1, 32'd1, ADD);
    @(negedge clk);
    chk("prereset_ready", 64'(bus.req_ready), 64'd2);
    tick();
    bus.req_valid = '0;
    chk("prereset_valid", 64'(bus.rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("async_rst_data",  64'(bus.rsp_data),  64'd0);
    set_req(0, 32'hFF00_FF00, 32'h0FF0_0FF0, AND);
    set_req(1, 32'd1, 32'd2, OR);
    bus.rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    sb_q.push_back('{id: 1'b0, data: 32'h0F00_0F00, onzc: 4'b0000, ill: 1'b0});
    @(negedge clk);
    chk("postreset_grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("postreset_valid", 64'(bus.rsp_valid), 64'd1);
    tick();
    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("final_idle_valid", 64'(bus.rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational ALU datapath between NUM_REQ requesters, e.g. the execute stage and the branch/address unit.
- Round-robin arbitration over valid/ready request channels. The granted operands and control code are driven onto the ALU, and its C/ONZC outputs are captured into one result register.
- Each result is returned on a valid/ready response channel tagged with the requester index.
- Single outstanding operation, with back-to-back issue when the response drains in the same cycle.

Parameters:
- REG_BITS, 32, operand/result width (matches ALU).
- NUM_REQ, 2, number of requesters (≥2).
- ID_BITS, $clog2(NUM_REQ), width of the response requester tag.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ×REG_BITS  operand A per requester.
- req_b  input  NUM_REQ×REG_BITS  operand B per requester.
- req_ctrl  input  NUM_REQ×4  ALU control code per requester.
- alu_a  output  REG_BITS  to ALU A.
- alu_b  output  REG_BITS  to ALU B.
- alu_ctrl  output  4  to ALU ctrl.
- alu_c  input  REG_BITS  ALU result C (combinational).
- alu_onzc  input  4  ALU flags {O,N,Z,C}.
- rsp_valid  output  1  result register holds a result.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_BITS  index of the requester that issued the result.
- rsp_data  output  REG_BITS  captured C.
- rsp_onzc  output  4  captured flags.
- rsp_illegal  output  1  ctrl code was >4'b1001 (result is 0).

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0; rsp_id/rsp_data/rsp_onzc/rsp_illegal=0.
  - rr_ptr=0; req_ready=0.
- State = rsp_valid register:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_issue = !rsp_valid | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - grant = first asserted req_valid index searching from rr_ptr upward with wrap-around modulo NUM_REQ.
  - grant is none if no req_valid.
- req_ready[i] = can_issue & (grant==i). At most one bit is set.
- alu_a/alu_b/alu_ctrl = granted requester's fields; all-zero when there is no grant. The ALU is never driven with X.
- Accept (fire) = req_valid[g] & req_ready[g]. On the fire clock edge:
  - rsp_data<=alu_c, rsp_onzc<=alu_onzc, rsp_id<=g.
  - rsp_illegal<=(req_ctrl[g]>4'b1001).
  - rsp_valid<=1.
  - rr_ptr<=(g+1) mod NUM_REQ.
- Latency: request accepted in cycle N gives rsp_valid in cycle N+1 with stable data.
- Drain without fire (rsp_valid & rsp_ready & no request): rsp_valid<=0. Data registers keep their old value.
- Simultaneous drain + fire: rsp_valid stays 1 and the registers load the new result. This gives one result per cycle sustained.
- FULL & !rsp_ready: all req_ready=0. rsp_* hold stable until accepted.
- Requester rule: req_a/b/ctrl stable while req_valid & !req_ready. A requester may drop valid before acceptance with no side effect.
- rr_ptr changes only on fire. Idle cycles do not rotate priority.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 fires.
- Reset mid-operation: any held result is discarded and priority returns to requester 0.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_op_e (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SLTU=7, SRL=8, SRA=9).
  - localparam ALU_OP_MAX=4'd9.
  - ONZC bit-index constants: FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_O=3.
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr; outputs one-hot grant, grant index, any_grant. Reused by later shared units.

Test Plan:
- Req0 ADD a=0xFFFFFFFF b=1, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_data=0, rsp_onzc=4'b0011, rsp_illegal=0.
- Req1 ADD a=0x7FFFFFFF b=1 → rsp_data=0x80000000, rsp_onzc=4'b1100, rsp_id=1.
- Both requesters valid every cycle for 6 cycles, rsp_ready=1, ops SUB 5-5 / SRA 0x80000000>>4:
  - rsp_id sequence 0,1,0,1,0,1.
  - SUB rsp_onzc=4'b0010; SRA rsp_data=0xF8000000.
  - One result per cycle.
- Result pending with rsp_ready=0 for 3 cycles while req1 valid → req_ready=0 throughout and rsp_* stable. Raise rsp_ready → same cycle req_ready[1]=1, new result the next cycle.
- Req0 ctrl=4'b1111 → rsp_illegal=1, rsp_data=0, rsp_onzc=0.
- Assert rst_n=0 while rsp_valid=1, mid-stream → rsp_valid=0 asynchronously. After release, both requesters valid → req0 granted first.
